// File: rtl/exmem_reg.sv
// EX/MEM pipeline register: stall/flush/valid tracking, WB store-data refresh and misalignment fault.
// Optional build macro EXMEM_PERF_EN adds saturating stall/bubble/fault performance counters.
module exmem_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        EX_valid,
   input  logic [63:0] EX_ALUResult,
   input  logic [63:0] EX_RegB_content,
   input  logic [4:0]  EX_Rt,
   input  logic [4:0]  EX_Rd,
   input  logic        EX_MemWrite,
   input  logic        EX_read_enable,
   input  logic        EX_RegWrite,
   input  logic        EX_MemToReg,
   input  logic [3:0]  EX_xfer_size,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_Rd,
   input  logic [63:0] WB_result,
   output logic        EXMEM_valid,
   output logic [63:0] EXMEM_ALUResult,
   output logic [63:0] EXMEM_RegB_content,
   output logic [4:0]  EXMEM_Rd,
   output logic        EXMEM_MemWrite,
   output logic        EXMEM_read_enable,
   output logic        EXMEM_RegWrite,
   output logic        EXMEM_MemToReg,
   output logic [3:0]  EXMEM_xfer_size,
   output logic        EXMEM_fault
`ifdef EXMEM_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_bubbles,
   output logic [31:0] perf_faults
`endif
);

   localparam int unsigned XLEN = 64;
   localparam int unsigned RW   = 5;
   localparam int unsigned SW   = 4;
   localparam logic [RW-1:0] XZR = RW'(31);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] alu_q, alu_d;
   logic [XLEN-1:0] regb_q, regb_d;
   logic [RW-1:0]   rt_q, rt_d;
   logic [RW-1:0]   rd_q, rd_d;
   logic            mw_q, mw_d;
   logic            re_q, re_d;
   logic            rw_q, rw_d;
   logic            m2r_q, m2r_d;
   logic [SW-1:0]   size_q, size_d;
   logic            fault_q, fault_d;

   logic            size_legal;
   logic [XLEN-1:0] align_mask;
   logic            misaligned;
   logic            fault_in;
   logic            ex_bypass;
   logic            hold_refresh;

   // Alignment check from the raw EX inputs; the size mask only matters when the size is legal.
   always_comb begin
      size_legal   = (EX_xfer_size == SW'(1)) || (EX_xfer_size == SW'(2)) ||
                     (EX_xfer_size == SW'(4)) || (EX_xfer_size == SW'(8));
      align_mask   = XLEN'(EX_xfer_size - SW'(1));
      misaligned   = (EX_ALUResult & align_mask) != '0;
      fault_in     = EX_valid & (EX_MemWrite | EX_read_enable) & (~size_legal | misaligned);
      ex_bypass    = EX_MemWrite & WB_RegWrite & (WB_Rd == EX_Rt) & (EX_Rt != XZR);
      hold_refresh = valid_q & mw_q & WB_RegWrite & (WB_Rd == rt_q) & (rt_q != XZR);
   end

   always_comb begin
      valid_d = valid_q;
      alu_d   = alu_q;
      regb_d  = regb_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      mw_d    = mw_q;
      re_d    = re_q;
      rw_d    = rw_q;
      m2r_d   = m2r_q;
      size_d  = size_q;
      fault_d = fault_q;
      if (flush) begin
         // Bubble: datapath fields are left as they were.
         valid_d = 1'b0;
         mw_d    = 1'b0;
         re_d    = 1'b0;
         rw_d    = 1'b0;
         m2r_d   = 1'b0;
         fault_d = 1'b0;
      end else if (stall) begin
         if (hold_refresh) regb_d = WB_result;
      end else begin
         valid_d = EX_valid;
         alu_d   = EX_ALUResult;
         regb_d  = ex_bypass ? WB_result : EX_RegB_content;
         rt_d    = EX_Rt;
         rd_d    = EX_Rd;
         mw_d    = EX_MemWrite;
         re_d    = EX_read_enable;
         rw_d    = EX_RegWrite;
         m2r_d   = EX_MemToReg;
         size_d  = EX_xfer_size;
         fault_d = fault_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         alu_q   <= '0;
         regb_q  <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         mw_q    <= 1'b0;
         re_q    <= 1'b0;
         rw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         size_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         alu_q   <= alu_d;
         regb_q  <= regb_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         mw_q    <= mw_d;
         re_q    <= re_d;
         rw_q    <= rw_d;
         m2r_q   <= m2r_d;
         size_q  <= size_d;
         fault_q <= fault_d;
      end
   end

   // A faulting slot must not touch memory or the register file.
   assign EXMEM_valid        = valid_q;
   assign EXMEM_ALUResult    = alu_q;
   assign EXMEM_RegB_content = regb_q;
   assign EXMEM_Rd           = rd_q;
   assign EXMEM_xfer_size    = size_q;
   assign EXMEM_MemWrite     = mw_q & valid_q & ~fault_q;
   assign EXMEM_read_enable  = re_q & valid_q & ~fault_q;
   assign EXMEM_RegWrite     = rw_q & valid_q & ~fault_q;
   assign EXMEM_MemToReg     = m2r_q & valid_q;
   assign EXMEM_fault        = fault_q & valid_q;

`ifdef EXMEM_PERF_EN
   localparam int unsigned PW = 32;
   logic [PW-1:0] stall_cnt_q, bubble_cnt_q, fault_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         fault_cnt_q  <= '0;
      end else begin
         if (!flush && stall && valid_q && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + PW'(1);
         if (flush && (bubble_cnt_q != '1))
            bubble_cnt_q <= bubble_cnt_q + PW'(1);
         if (!flush && !stall && fault_in && (fault_cnt_q != '1))
            fault_cnt_q <= fault_cnt_q + PW'(1);
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_bubbles      = bubble_cnt_q;
   assign perf_faults       = fault_cnt_q;
`endif

endmodule
